operand_select_pipe: RTL
========================

// Module: operand_select_pipe
// PURPOSE
//  Registered, parametrised ALU operand-select stage for KGP_RISC, between register read and the ALU.
//  Picks inp1/inp2 from rs, rt, shamt or the extended immediate, chosen by opcode/fcode.
//  Applies single-source result forwarding, gives 1-cycle latency with valid/ready backpressure,
//  supports flush, and counts stall cycles.
// PARAMETERS
//  DATA_W   32  operand/result width
//  IMM_W    22  immediate field width (IMM_W < DATA_W)
//  SHAMT_W  5   shift-amount field width
//  REG_AW   5   register index width; index 0 is hardwired zero
//  CNT_W    16  stall counter width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-low reset
//  flush      in   1        synchronous squash of the held operand pair
//  in_valid   in   1        input bundle valid
//  in_ready   out  1        stage can accept a bundle this cycle
//  rs, rt     in   DATA_W   register-file read values
//  rs_idx     in   REG_AW   source index of rs
//  rt_idx     in   REG_AW   source index of rt
//  shamt      in   SHAMT_W  shift amount
//  imm        in   IMM_W    immediate
//  opcode     in   3        instruction class
//  fcode      in   4        function code
//  fwd_en     in   1        forwarding source valid
//  fwd_idx    in   REG_AW   destination index of forwarded result
//  fwd_data   in   DATA_W   forwarded result
//  out_valid  out  1        inp1/inp2 valid
//  out_ready  in   1        ALU accepts the operands
//  inp1       out  DATA_W   ALU operand 1
//  inp2       out  DATA_W   ALU operand 2
//  out_opcode out  3        registered opcode
//  out_fcode  out  4        registered fcode
//  stall_cnt  out  CNT_W    saturating count of stall cycles
// BEHAVIOUR
//  Reset (rst=0, async): out_valid=0, inp1=inp2=0, out_opcode=0, out_fcode=0, stall_cnt=0.
//    Takes effect immediately and drops any held bundle.
//  Forwarding: src_a = fwd_data when fwd_en && fwd_idx==rs_idx && rs_idx!=0, else rs.
//    src_b is the same rule applied to rt/rt_idx.
//  Selection (combinational, from the raw inputs):
//    opcode 0, fcode[3:2]==2'b01 -> inp1=src_a, inp2=zero-ext shamt (shift-immediate)
//    opcode 0, other fcode      -> inp1=src_a, inp2=src_b
//    opcode 1                   -> inp1=src_a, inp2=sign-ext imm (bit IMM_W-1 replicated)
//    opcode 2                   -> inp1=src_a, inp2=zero-ext imm
//    opcode 3..7                -> inp1=src_a, inp2=src_b
//  Handshake: in_ready = !out_valid || out_ready (combinational).
//    Load when in_valid && in_ready. Latency is 1 cycle.
//  Stall hold: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
//  Output valid: on a load, out_valid=1. When out_ready and there is no load, out_valid=0.
//    Back-to-back transfers are possible every cycle.
//  Flush: clears out_valid next edge and overrides a simultaneous load.
//    Data regs may keep stale values. in_ready is not gated by flush.
//  stall_cnt increments every cycle with out_valid && !out_ready.
//    It saturates at all-ones and does not wrap. Only reset clears it.
// TESTING
//  1) rs=10,rt=15,shamt=20,imm=25, op=0,fc=0000, out_ready=1 -> next cycle inp1=10, inp2=15, out_valid=1.
//  2) op=0,fc=0100 -> inp2=20. op=1,imm=22'h3FFFFF -> inp2=32'hFFFFFFFF. op=2, same imm -> inp2=32'h003FFFFF.
//  3) fwd_en=1,fwd_idx=3,fwd_data=99; rs_idx=3 -> inp1=99. rs_idx=0,fwd_idx=0 -> inp1=rs.
//  4) out_ready=0 for 5 cycles with out_valid=1 -> outputs stable, in_ready=0, stall_cnt=5.
//     With CNT_W=2 the counter saturates at 3.
//  5) flush with in_valid=1 in the same cycle -> out_valid=0 next cycle.
//  6) rst low mid-stall -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_select_pipe.sv
// operand_select_pipe
//   Registered ALU operand-select stage for KGP_RISC, sitting between register
//   read and the ALU. Chooses inp1/inp2 from rs, rt, shamt or the extended
//   immediate according to opcode/fcode, applies single-source result
//   forwarding, and presents the pair one cycle later under valid/ready
//   handshaking. Supports a synchronous flush and keeps a saturating count of
//   stall cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      squash the held operand pair at the next edge
//   in_valid   input bundle valid
//   in_ready   stage can accept a bundle this cycle
//   rs, rt     register-file read values
//   rs_idx     source index of rs (index 0 is hardwired zero)
//   rt_idx     source index of rt
//   shamt      shift amount
//   imm        immediate
//   opcode     instruction class
//   fcode      function code
//   fwd_en     forwarding source valid
//   fwd_idx    destination index of the forwarded result
//   fwd_data   forwarded result
//   out_valid  inp1/inp2 valid
//   out_ready  ALU accepts the operands
//   inp1       ALU operand 1
//   inp2       ALU operand 2
//   out_opcode registered opcode
//   out_fcode  registered fcode
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module operand_select_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned IMM_W   = 22,
   parameter int unsigned SHAMT_W = 5,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  rs,
   input  logic [DATA_W-1:0]  rt,
   input  logic [REG_AW-1:0]  rs_idx,
   input  logic [REG_AW-1:0]  rt_idx,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [IMM_W-1:0]   imm,
   input  logic [2:0]         opcode,
   input  logic [3:0]         fcode,
   input  logic               fwd_en,
   input  logic [REG_AW-1:0]  fwd_idx,
   input  logic [DATA_W-1:0]  fwd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  inp1,
   output logic [DATA_W-1:0]  inp2,
   output logic [2:0]         out_opcode,
   output logic [3:0]         out_fcode,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] sel1;
   logic [DATA_W-1:0] sel2;
   logic              load;
   logic              stall;

   // Register 0 never takes a forwarded value: it always reads as rs/rt.
   always_comb begin
      src_a = rs;
      src_b = rt;
      if (fwd_en && (fwd_idx == rs_idx) && (rs_idx != '0))
         src_a = fwd_data;
      if (fwd_en && (fwd_idx == rt_idx) && (rt_idx != '0))
         src_b = fwd_data;
   end

   always_comb begin
      sel1 = src_a;
      sel2 = src_b;
      case (opcode)
         3'd0: begin
            if (fcode[3:2] == 2'b01)
               sel2 = {{(DATA_W-SHAMT_W){1'b0}}, shamt};
         end
         3'd1: sel2 = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
         3'd2: sel2 = {{(DATA_W-IMM_W){1'b0}}, imm};
         default: sel2 = src_b;
      endcase
   end

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready;
   assign stall    = out_valid && !out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         inp1       <= '0;
         inp2       <= '0;
         out_opcode <= '0;
         out_fcode  <= '0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (load)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;

         if (load && !flush) begin
            inp1       <= sel1;
            inp2       <= sel2;
            out_opcode <= opcode;
            out_fcode  <= fcode;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule
